id_ex_stage_reg: RTL
====================

// Module: id_ex_stage_reg
// PURPOSE
// - ID/EX pipeline register with load-use hazard detection; sits between decode and execute.
// - Supplies IDEX_Rs/IDEX_Rt/aluop and operands to the EX-stage forwarding unit and ALU.
// - Detects load-use hazards against the instruction it holds, then stalls IF/ID and inserts a bubble.
// - Also handles branch flush and back-pressure freeze from MEM.
// PARAMETERS
// - DATA_W   32  width of operand/immediate datapath
// - CNT_W    16  width of perf counters (used only with IDEX_PERF_CNT_EN)
// PORTS
// - clk          in   1       rising-edge clock
// - rst          in   1       asynchronous, active-high reset
// - id_valid     in   1       decode slot holds a real instruction
// - id_rs,id_rt  in   5       source register indices from decode
// - id_rd        in   5       destination index (already muxed rt/rd)
// - id_uses_rt   in   1       instruction reads rt as a source (R-type, store, beq)
// - id_aluop     in   6       ALU opcode
// - id_regwrite  in   1       decoded RegWrite
// - id_memread   in   1       decoded MemRead (load)
// - id_memwrite  in   1       decoded MemWrite (store)
// - id_rdata1/2  in   DATA_W  register-file read data
// - id_imm       in   DATA_W  sign-extended immediate
// - flush        in   1       branch taken in EX; squash the decode instruction
// - mem_stall    in   1       MEM not ready; freeze this stage
// - IDEX_Rs/Rt/Rd out 5       held indices (Rs/Rt go to forwarding unit)
// - ex_valid, ex_aluop[6], ex_regwrite, ex_memread, ex_memwrite  out  held control
// - ex_rdata1/2, ex_imm  out  DATA_W  held operands
// - stall_ifid   out  1       combinational: hold PC and IF/ID this cycle
// - bubble_cnt, stall_cnt  out  CNT_W  perf counters
// BEHAVIOUR
// - Reset (async, immediate): every registered output = 0, including counters.
// - Latency: one cycle; inputs sampled on clk rise appear on outputs after that edge.
// - hazard = ex_valid & ex_memread & IDEX_Rt!=0 & id_valid
//            & (id_rs==IDEX_Rt | (id_uses_rt & id_rt==IDEX_Rt)).
// - Per-edge priority is rst > mem_stall > flush > hazard > load:
//   - mem_stall=1: all registers hold; stall_ifid=1.
//   - flush=1: load bubble (valid, regwrite, memread, memwrite = 0; indices/aluop/data = 0); stall_ifid=0.
//   - hazard=1: load bubble; stall_ifid=1 so decode re-presents the same instruction next cycle.
//   - otherwise: capture all id_* fields; ex_valid=id_valid.
//     - id_valid=0 captures control bits as 0.
// - stall_ifid = mem_stall | (hazard & ~flush); purely combinational, no registered state.
// - A load-use stall lasts exactly one cycle: the bubble clears ex_memread, so hazard drops.
// - Back-to-back loads (lw r2; lw r3,0(r2)): one bubble, then normal capture.
// - rst asserted mid-stall: outputs go to 0 at once; stall_ifid=0 while rst=1.
// - Register 0 is never a hazard source; bubbles never assert regwrite or memwrite.
// CONFIGURATION
// - Macro IDEX_PERF_CNT_EN defined:
//   - bubble_cnt increments on each edge that loads a bubble (flush or hazard).
//   - stall_cnt increments on each edge with stall_ifid=1.
//   - Both saturate at all-ones and clear only on rst.
// - Macro not defined: counter logic is absent; bubble_cnt and stall_cnt are tied to 0.
// TESTING
// - Reset: rst=1 while outputs are random -> all outputs 0 immediately (before a clk edge).
// - Pass-through: id_valid=1, rs=1, rt=2, rd=3, aluop=6'h20, rdata1=5, rdata2=7
//   -> after the edge IDEX_Rs=1, Rt=2, Rd=3, ex_valid=1, stall_ifid=0.
// - Load-use: hold lw (memread=1, Rt=4); decode add with rs=4
//   -> stall_ifid=1; next edge loads a bubble; following edge captures add, stall_ifid=0.
// - Same case, but decode slti with rt=4 and id_uses_rt=0 -> no hazard, no bubble.
//   With rt=0 as the load target -> no hazard.
// - Flush + hazard in the same cycle -> bubble, stall_ifid=0.
//   mem_stall=1 for 3 cycles -> outputs frozen for 3 cycles, stall_ifid=1 throughout.
// - IDEX_PERF_CNT_EN: 2 hazards + 1 flush + 3 mem_stall cycles
//   -> bubble_cnt=3, stall_cnt=5. Without the macro -> both counters 0.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use hazard detection.
// It holds the decoded instruction for EX and feeds the forwarding unit and ALU.
// The stage squashes on a branch flush and freezes while MEM applies back-pressure.
// Optional macro IDEX_PERF_CNT_EN adds saturating bubble and stall counters.
// When the macro is undefined, both counter outputs are tied to 0.
module id_ex_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic              id_uses_rt,
   input  logic [5:0]        id_aluop,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic [DATA_W-1:0] id_rdata1,
   input  logic [DATA_W-1:0] id_rdata2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              flush,
   input  logic              mem_stall,
   output logic [4:0]        IDEX_Rs,
   output logic [4:0]        IDEX_Rt,
   output logic [4:0]        IDEX_Rd,
   output logic              ex_valid,
   output logic [5:0]        ex_aluop,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic [DATA_W-1:0] ex_rdata1,
   output logic [DATA_W-1:0] ex_rdata2,
   output logic [DATA_W-1:0] ex_imm,
   output logic              stall_ifid,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              r_valid;
   logic [4:0]        r_rs;
   logic [4:0]        r_rt;
   logic [4:0]        r_rd;
   logic [5:0]        r_aluop;
   logic              r_regwrite;
   logic              r_memread;
   logic              r_memwrite;
   logic [DATA_W-1:0] r_rdata1;
   logic [DATA_W-1:0] r_rdata2;
   logic [DATA_W-1:0] r_imm;

   logic w_hazard;
   logic w_bubble;
   logic w_stall;

   // Load-use hazard: the held load writes a register the decode instruction reads.
   // Register 0 is never a hazard source.
   always_comb begin
      w_hazard = r_valid & r_memread & (r_rt != 5'd0) & id_valid
               & ((id_rs == r_rt) | (id_uses_rt & (id_rt == r_rt)));
      w_bubble = ~mem_stall & (flush | w_hazard);
      // Gating with rst keeps IF/ID free-running while reset is held.
      w_stall  = ~rst & (mem_stall | (w_hazard & ~flush));
   end

   assign stall_ifid = w_stall;

   // Pipeline register: freeze on mem_stall, bubble on flush or hazard, else capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_rd       <= '0;
         r_aluop    <= '0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_rdata1   <= '0;
         r_rdata2   <= '0;
         r_imm      <= '0;
      end else if (mem_stall) begin
         r_valid    <= r_valid;
      end else if (w_bubble) begin
         r_valid    <= 1'b0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_rd       <= '0;
         r_aluop    <= '0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_rdata1   <= '0;
         r_rdata2   <= '0;
         r_imm      <= '0;
      end else begin
         // An empty decode slot must not carry side-effecting control into EX.
         r_valid    <= id_valid;
         r_rs       <= id_rs;
         r_rt       <= id_rt;
         r_rd       <= id_rd;
         r_aluop    <= id_aluop;
         r_regwrite <= id_valid & id_regwrite;
         r_memread  <= id_valid & id_memread;
         r_memwrite <= id_valid & id_memwrite;
         r_rdata1   <= id_rdata1;
         r_rdata2   <= id_rdata2;
         r_imm      <= id_imm;
      end
   end

   assign IDEX_Rs     = r_rs;
   assign IDEX_Rt     = r_rt;
   assign IDEX_Rd     = r_rd;
   assign ex_valid    = r_valid;
   assign ex_aluop    = r_aluop;
   assign ex_regwrite = r_regwrite;
   assign ex_memread  = r_memread;
   assign ex_memwrite = r_memwrite;
   assign ex_rdata1   = r_rdata1;
   assign ex_rdata2   = r_rdata2;
   assign ex_imm      = r_imm;

`ifdef IDEX_PERF_CNT_EN
   logic [CNT_W-1:0] r_bubble_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   // Saturating perf counters, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bubble_cnt <= '0;
         r_stall_cnt  <= '0;
      end else begin
         if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}}))
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
         if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign bubble_cnt = r_bubble_cnt;
   assign stall_cnt  = r_stall_cnt;
`else
   assign bubble_cnt = '0;
   assign stall_cnt  = '0;
`endif

endmodule
